netbus_rr_arbiter: RTL and testbench
====================================

Name: netbus_rr_arbiter

Overview:
- Round-robin, packet-locked N:1 arbiter that merges several NetBus requester streams onto one NetBus output link.
- Each flit is one NetBus word, W = DATA_WIDTH*9+14 bits, laid out MSB to LSB as:
  - DATAX (8*DATA_WIDTH)
  - STRB (DATA_WIDTH)
  - CMD[1:0]
  - DID[4:0]
  - SID[4:0]
  - FIRST
  - LAST (bit 0)
- Once a requester wins, it owns the link until its LAST flit is accepted. Packets are never interleaved.
- Sits in front of a shared link or router port; output is one register stage with valid/ready flow control.

Parameters:
- DATA_WIDTH, 4, byte lanes per flit; W = DATA_WIDTH*9+14.
- PORTS, 4, number of requesters; legal range 2..8.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- S_DATA  in  PORTS*W  requester flits; port i occupies bits [i*W+W-1 : i*W].
- S_VALID  in  PORTS  per-requester flit valid.
- S_READY  out  PORTS  per-requester flit accept.
- M_DATA  out  W  output flit (registered).
- M_VALID  out  1  output flit valid.
- M_READY  in  1  downstream accept.
- GRANT  out  PORTS  one-hot current owner; all zero when idle.
- BUSY  out  1  high while in LOCKED.

Behaviour:
- Reset (RST=1 at an edge) forces:
  - state=IDLE, GRANT=0, BUSY=0, S_READY=0, M_VALID=0, M_DATA=0;
  - round-robin pointer LASTWIN=PORTS-1, so port 0 has highest priority first.
- Reset mid-packet: the in-flight packet is abandoned and any flit in the output register is discarded. No recovery flit is emitted.
- Transfer rules:
  - An input transfer occurs on port i when S_VALID[i] and S_READY[i] are both high at an edge.
  - An output transfer occurs when M_VALID and M_READY are both high at an edge.
- States: IDLE, LOCKED.
- IDLE:
  - If any S_VALID bit is set, pick the first set bit searching LASTWIN+1, LASTWIN+2, … modulo PORTS.
  - At the edge: GRANT <= onehot(winner), LASTWIN <= winner, state <= LOCKED.
  - S_READY stays 0 in IDLE, so arbitration costs exactly one cycle per packet.
- LOCKED:
  - S_READY[g] = (GRANT[g]) & (~M_VALID | M_READY). All non-granted S_READY bits are 0.
  - On an input transfer from g: M_DATA <= S_DATA[g], M_VALID <= 1.
  - On an output transfer with no input transfer in the same cycle: M_VALID <= 0.
  - When the accepted flit has LAST (bit 0) = 1: state <= IDLE and GRANT <= 0 at the same edge. The flit still drains through the output register normally.
- Throughput: full rate (one flit per cycle) while locked with M_READY held high. Plus one idle cycle between packets.
- Latency:
  - S_VALID rising in IDLE → S_READY high the next cycle.
  - Flit accepted at edge N → visible on M_DATA/M_VALID after edge N.
- Boundary conditions:
  - Granted requester drops S_VALID mid-packet: lock is held indefinitely; no timeout and no re-arbitration.
  - Single-flit packet (FIRST=LAST=1): locks for one transfer, then returns to IDLE.
  - FIRST is passed through unchecked. A packet is defined solely by LAST.
  - M_READY low: M_DATA/M_VALID hold stable and S_READY is 0. There is no data loss and no duplication.
  - Simultaneous requests in IDLE: exactly one winner, chosen by the rotating pointer.
  - A requester raising S_VALID while another owns the link waits; its request is evaluated at the next IDLE cycle.
- No field of the flit is modified; M_DATA is a bit-exact copy of the accepted S_DATA slice.

Test Plan:
- Reset then idle: RST=1 for 2 cycles → all outputs 0, GRANT=0. With PORTS=4 and all S_VALID=1 after reset → first GRANT=4'b0001, then 4'b0010, 4'b0100, 4'b1000, 4'b0001 (single-flit packets).
- Multi-flit lock: port 2 sends 3 flits (LAST only on the 3rd) while port 0 holds S_VALID=1 → output order is P2f0, P2f1, P2f2, then P0. S_READY[0] stays 0 throughout P2's packet, and GRANT=4'b0100 is constant.
- Backpressure: M_READY=0 for 5 cycles mid-packet → M_DATA stable and S_READY=0 for those 5 cycles. After release, the flit sequence is bit-exact with no gaps beyond the stall.
- Requester stall: granted port 1 drops S_VALID for 4 cycles mid-packet while port 3 is valid → GRANT stays 4'b0010 and port 3 is not served until P1's LAST is accepted.
- Reset mid-packet: assert RST after 1 of 3 flits is accepted → next cycle M_VALID=0, GRANT=0, LASTWIN=3. The next arbitration starts from port 0.
- Field integrity: random S_DATA with DATA_WIDTH=4 (W=50), e.g. CMD=2'b10, DID=5'd17, SID=5'd3, STRB=4'hA → the scoreboard sees identical 50-bit words at M_DATA in acceptance order.

Source files
------------

// File: rtl/netbus_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | netbus_rr_arbiter                                                          |
// | Round-robin, packet-locked N:1 NetBus arbiter with a registered output.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module netbus_rr_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int PORTS      = 4
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic [PORTS*(DATA_WIDTH*9+14)-1:0]    S_DATA,
   input  logic [PORTS-1:0]                      S_VALID,
   output logic [PORTS-1:0]                      S_READY,
   output logic [DATA_WIDTH*9+13:0]              M_DATA,
   output logic                                  M_VALID,
   input  logic                                  M_READY,
   output logic [PORTS-1:0]                      GRANT,
   output logic                                  BUSY
);

   localparam int W  = DATA_WIDTH*9+14;
   localparam int PW = $clog2(PORTS);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [PORTS-1:0] r_grant;
   logic [PORTS-1:0] w_grant_nx;
   logic [PW-1:0]    r_lastwin;
   logic [PW-1:0]    w_lastwin_nx;
   logic [PW-1:0]    w_winner;
   logic             w_found;
   logic [W-1:0]     r_mdata;
   logic [W-1:0]     w_sel_data;
   logic             r_mvalid;
   logic             w_out_free;
   logic             w_in_xfer;
   logic [PORTS-1:0] w_sready;

   // Rotating search: first requester after the previous winner, modulo PORTS.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      w_found  = 1'b0;
      w_winner = r_lastwin;
      for (int k = 1; k <= PORTS; k++) begin
         idx = PW'((int'(r_lastwin) + k) % PORTS);
         if (!w_found && S_VALID[idx]) begin
            w_found  = 1'b1;
            w_winner = idx;
         end
      end
   end

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (r_grant[i]) begin
            w_sel_data = S_DATA[i*W +: W];
         end
      end
   end

   assign w_out_free = ~r_mvalid | M_READY;
   assign w_sready   = (r_state == ST_LOCKED && w_out_free) ? r_grant : '0;
   assign w_in_xfer  = |(S_VALID & w_sready);

   always_comb begin
      w_state_nx   = r_state;
      w_grant_nx   = r_grant;
      w_lastwin_nx = r_lastwin;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nx   = ST_LOCKED;
               w_grant_nx   = PORTS'(1) << w_winner;
               w_lastwin_nx = w_winner;
            end
         end
         ST_LOCKED: begin
            // Lock releases on the edge that accepts the LAST flit.
            if (w_in_xfer && w_sel_data[0]) begin
               w_state_nx = ST_IDLE;
               w_grant_nx = '0;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_grant_nx = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_lastwin <= PW'(PORTS-1);
      end else begin
         r_state   <= w_state_nx;
         r_grant   <= w_grant_nx;
         r_lastwin <= w_lastwin_nx;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_mdata  <= '0;
         r_mvalid <= 1'b0;
      end else if (w_in_xfer) begin
         r_mdata  <= w_sel_data;
         r_mvalid <= 1'b1;
      end else if (M_READY) begin
         r_mvalid <= 1'b0;
      end
   end

   assign S_READY = w_sready;
   assign M_DATA  = r_mdata;
   assign M_VALID = r_mvalid;
   assign GRANT   = r_grant;
   assign BUSY    = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_netbus_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_netbus_rr_arbiter                                                       |
// | Randomised bench with a packet-level reference model and output scoreboard.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_netbus_rr_arbiter;

   localparam int DATA_WIDTH = 4;
   localparam int PORTS      = 4;
   localparam int W          = DATA_WIDTH*9+14;
   localparam int DEPTH      = 1024;

   logic               CLK = 1'b0;
   logic               RST;
   logic [PORTS*W-1:0] S_DATA;
   logic [PORTS-1:0]   S_VALID;
   logic [PORTS-1:0]   S_READY;
   logic [W-1:0]       M_DATA;
   logic               M_VALID;
   logic               M_READY;
   logic [PORTS-1:0]   GRANT;
   logic               BUSY;

   always #5 CLK = ~CLK;

   netbus_rr_arbiter #(.DATA_WIDTH(DATA_WIDTH), .PORTS(PORTS)) dut (
      .CLK(CLK), .RST(RST), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
      .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .GRANT(GRANT), .BUSY(BUSY)
   );

   int total = 0;
   int bad   = 0;

   // Per-requester flit source, and the packet-level view of the link.
   logic [W-1:0]     fmem [PORTS][DEPTH];
   int               head [PORTS];
   int               tail [PORTS];
   logic [W-1:0]     expq [$];
   int               owner;
   int               lastwin;
   bit               outfull;
   logic [W-1:0]     outdata;
   logic [PORTS-1:0] vmask;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] mkflit(input logic [31:0] dx, input logic [3:0] st,
                                           input logic [1:0] cmd, input logic [4:0] did,
                                           input logic [4:0] sid, input logic fi, input logic la);
      return {dx, st, cmd, did, sid, fi, la};
   endfunction

   task automatic add_pkt(input int p, input int len);
      for (int f = 0; f < len; f++) begin
         if (tail[p] < DEPTH) begin
            fmem[p][tail[p]] = mkflit($urandom, 4'($urandom), 2'($urandom), 5'($urandom),
                                      5'($urandom), 1'(f == 0), 1'(f == len-1));
            tail[p]++;
         end
      end
   endtask

   task automatic step(input int vpct, input int rpct, input bit rst_now);
      logic [PORTS-1:0] eg;
      logic [PORTS-1:0] er;
      logic [W-1:0]     flit;
      int               p;
      bit               found;
      @(posedge CLK);
      #1;
      RST = rst_now;
      for (int i = 0; i < PORTS; i++) begin
         S_VALID[i] = vmask[i] && (head[i] < tail[i]) && (int'($urandom_range(99)) < vpct);
         S_DATA[i*W +: W] = (head[i] < tail[i]) ? fmem[i][head[i]] : W'({$urandom, $urandom});
      end
      M_READY = (int'($urandom_range(99)) < rpct);
      @(negedge CLK);
      eg = '0;
      er = '0;
      if (owner >= 0) begin
         eg[owner] = 1'b1;
         if (!outfull || M_READY) er[owner] = 1'b1;
      end
      chk("grant",   64'(GRANT),   64'(eg));
      chk("busy",    64'(BUSY),    64'(owner >= 0));
      chk("s_ready", 64'(S_READY), 64'(er));
      chk("m_valid", 64'(M_VALID), 64'(outfull));
      chk("m_data",  64'(M_DATA),  64'(outdata));
      // Advance the reference view across the coming edge.
      if (rst_now) begin
         owner   = -1;
         lastwin = PORTS-1;
         outfull = 1'b0;
         outdata = '0;
         expq.delete();
      end else if (owner < 0) begin
         if (outfull && M_READY) outfull = 1'b0;
         found = 1'b0;
         for (int k = 1; k <= PORTS; k++) begin
            p = (lastwin + k) % PORTS;
            if (!found && S_VALID[p]) begin
               found = 1'b1;
               owner = p;
            end
         end
         if (found) lastwin = owner;
      end else begin
         if (S_VALID[owner] && (!outfull || M_READY)) begin
            flit = fmem[owner][head[owner]];
            head[owner]++;
            expq.push_back(flit);
            outdata = flit;
            outfull = 1'b1;
            if (flit[0]) owner = -1;
         end else if (M_READY) begin
            outfull = 1'b0;
         end
      end
   endtask

   function automatic bit pending();
      bit r;
      r = (owner >= 0) || outfull || (expq.size() != 0);
      for (int i = 0; i < PORTS; i++) if (head[i] < tail[i]) r = 1'b1;
      return r;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      vmask = '1;
      while (pending() && n < 3000) begin
         step(100, 100, 1'b0);
         n++;
      end
      total++;
      if (pending()) begin
         bad++;
         $display("FAIL drain_timeout: actual=pending required=idle");
      end
   endtask

   task automatic wait_head(input int p, input int target);
      int n;
      n = 0;
      while (head[p] < target && n < 200) begin
         step(100, 100, 1'b0);
         n++;
      end
      total++;
      if (head[p] < target) begin
         bad++;
         $display("FAIL accept_timeout: actual=%0d required=%0d", head[p], target);
      end
   endtask

   // Scoreboard monitor: every output transfer must match the oldest accepted flit.
   always @(negedge CLK) begin
      logic [W-1:0] e;
      if (!RST && M_VALID && M_READY) begin
         total++;
         if (expq.size() == 0) begin
            bad++;
            $display("FAIL sb_data: actual=%0h required=none", M_DATA);
         end else begin
            e = expq.pop_front();
            if (M_DATA !== e) begin
               bad++;
               $display("FAIL sb_data: actual=%0h required=%0h", M_DATA, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [PORTS-1:0] gseq [$];
      logic [PORTS-1:0] gexp [5];
      logic [PORTS-1:0] lastg;
      int               h;
      RST     = 1'b1;
      S_VALID = '0;
      S_DATA  = '0;
      M_READY = 1'b0;
      vmask   = '1;
      for (int i = 0; i < PORTS; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      owner   = -1;
      lastwin = PORTS-1;
      outfull = 1'b0;
      outdata = '0;

      step(0, 0, 1'b1);
      step(0, 0, 1'b1);
      chk("rst_grant",   64'(GRANT),   64'(0));
      chk("rst_busy",    64'(BUSY),    64'(0));
      chk("rst_mvalid",  64'(M_VALID), 64'(0));
      chk("rst_mdata",   64'(M_DATA),  64'(0));
      chk("rst_sready",  64'(S_READY), 64'(0));

      // Everyone requesting single-flit packets: grants must rotate from port 0.
      for (int p = 0; p < PORTS; p++) begin
         add_pkt(p, 1);
         add_pkt(p, 1);
      end
      gexp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      lastg = '0;
      for (int c = 0; c < 12; c++) begin
         step(100, 100, 1'b0);
         if (GRANT != '0 && lastg == '0) gseq.push_back(GRANT);
         lastg = GRANT;
      end
      for (int i = 0; i < 5; i++)
         chk("rr_order", (i < gseq.size()) ? 64'(gseq[i]) : 64'hdead, 64'(gexp[i]));
      drain();

      // Port 2 wins alone, then port 0 must wait through its 3-flit packet.
      add_pkt(2, 3);
      add_pkt(0, 1);
      vmask = 4'b0100;
      step(100, 100, 1'b0);
      vmask = '1;
      step(100, 100, 1'b0);
      chk("lock_grant", 64'(GRANT), 64'(4'b0100));
      drain();

      // Downstream stall mid-packet.
      add_pkt(1, 5);
      h = head[1];
      wait_head(1, h + 2);
      for (int c = 0; c < 5; c++) step(100, 0, 1'b0);
      drain();

      // Granted requester goes quiet while another waits.
      add_pkt(1, 3);
      add_pkt(3, 1);
      vmask = 4'b0010;
      h = head[1];
      wait_head(1, h + 1);
      vmask = 4'b1000;
      for (int c = 0; c < 4; c++) step(100, 100, 1'b0);
      chk("stall_grant", 64'(GRANT), 64'(4'b0010));
      drain();

      // Reset after the first of three flits.
      add_pkt(1, 3);
      h = head[1];
      wait_head(1, h + 1);
      step(0, 100, 1'b1);
      step(0, 0, 1'b0);
      chk("rstmid_mvalid", 64'(M_VALID), 64'(0));
      chk("rstmid_grant",  64'(GRANT),   64'(0));
      add_pkt(0, 1);
      add_pkt(2, 1);
      add_pkt(3, 1);
      step(100, 100, 1'b0);
      step(100, 100, 1'b0);
      chk("rstmid_first", 64'(GRANT), 64'(4'b0001));
      drain();

      // Known field pattern, then free-running random traffic.
      fmem[2][tail[2]] = mkflit(32'hDEADBEEF, 4'hA, 2'b10, 5'd17, 5'd3, 1'b1, 1'b1);
      tail[2]++;
      drain();
      for (int c = 0; c < 500; c++) begin
         for (int p = 0; p < PORTS; p++)
            if (head[p] == tail[p] && $urandom_range(3) == 0) add_pkt(p, int'($urandom_range(1, 4)));
         step(70, 60, 1'b0);
      end
      drain();
      chk("sb_empty", 64'(expq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
